button_event_ctrl: RTL and testbench



---
 rtl/button_event_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_button_event_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// Egg-timer button front end: debouncer sample strobe, per-button press/hold FSMs,
// and one valid/ready event port. Define BTN_AUTO_REPEAT_EN for auto-repeat events.
module button_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 100000,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  localparam int ID_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             sample_en,
  input  logic [N_BTN-1:0] db_level,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  output logic [1:0]       evt_type,
  input  logic             evt_ready,
  output logic             evt_overrun
);

  localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam int PW        = $clog2(TICK_DIV);

  // Pending-bit index equals the event type code.
  localparam int T_PRESS = 0;
  localparam int T_REL   = 1;
  localparam int T_LONG  = 2;
`ifdef BTN_AUTO_REPEAT_EN
  localparam int T_REP   = 3;
  localparam logic [3:0] TYPE_MASK = 4'b1111;
`else
  localparam logic [3:0] TYPE_MASK = 4'b0111;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_t;

  logic [PW-1:0] presc_reg;
  logic          sample_reg;
  logic          eval_reg;

  // sample_reg is decoded one count early so it is high exactly while count == TICK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg  <= '0;
      sample_reg <= 1'b0;
      eval_reg   <= 1'b0;
    end else begin
      presc_reg  <= (presc_reg == PW'(TICK_DIV - 1)) ? '0 : presc_reg + 1'b1;
      sample_reg <= (presc_reg == PW'(TICK_DIV - 2));
      eval_reg   <= sample_reg;
    end
  end

  assign sample_en = sample_reg;

  logic [N_BTN-1:0][3:0] pend_vec;
  logic [N_BTN-1:0][3:0] set_vec;
  logic [N_BTN-1:0][3:0] clr_vec;

  logic            arb_any;
  logic            arb_active;
  logic            arb_load;
  logic [ID_W-1:0] arb_id;
  logic [1:0]      arb_type;
  logic [3:0]      arb_pend;
  logic [3:0]      arb_onehot;
  logic            ovr_hit;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      state_t        state_reg;
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_inc;
      logic [3:0]    set_now;
      logic [3:0]    pend_reg;

      assign cnt_inc = (cnt_reg == CW'(MAX_TICKS)) ? cnt_reg : cnt_reg + 1'b1;

      always_comb begin
        set_now = '0;
        if (eval_reg) begin
          case (state_reg)
            S_IDLE:
              if (db_level[gi]) set_now[T_PRESS] = 1'b1;
            S_PRESSED:
              if (!db_level[gi]) set_now[T_REL] = 1'b1;
              else if (cnt_inc == CW'(LONG_TICKS)) set_now[T_LONG] = 1'b1;
            S_HELD:
              if (!db_level[gi]) set_now[T_REL] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
              else if (cnt_inc == CW'(REPEAT_TICKS)) set_now[T_REP] = 1'b1;
`endif
            default: ;
          endcase
        end
      end

      // FSM transitions follow the decoded events so state and pending bits never disagree.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg <= S_IDLE;
          cnt_reg   <= '0;
          pend_reg  <= '0;
        end else begin
          pend_reg <= ((pend_reg & ~clr_vec[gi]) | set_now) & TYPE_MASK;
          if (eval_reg) begin
            case (state_reg)
              S_IDLE:
                if (set_now[T_PRESS]) begin
                  state_reg <= S_PRESSED;
                  cnt_reg   <= '0;
                end
              S_PRESSED:
                if (set_now[T_REL]) begin
                  state_reg <= S_IDLE;
                  cnt_reg   <= '0;
                end else if (set_now[T_LONG]) begin
                  state_reg <= S_HELD;
                  cnt_reg   <= '0;
                end else begin
                  cnt_reg <= cnt_inc;
                end
              S_HELD:
                if (set_now[T_REL]) begin
                  state_reg <= S_IDLE;
                  cnt_reg   <= '0;
                end
`ifdef BTN_AUTO_REPEAT_EN
                else if (set_now[T_REP]) begin
                  cnt_reg <= '0;
                end else begin
                  cnt_reg <= cnt_inc;
                end
`endif
              default: begin
                state_reg <= S_IDLE;
                cnt_reg   <= '0;
              end
            endcase
          end
        end
      end

      assign set_vec[gi]  = set_now;
      assign pend_vec[gi] = pend_reg;
      assign clr_vec[gi]  = (arb_load && (arb_id == ID_W'(gi))) ? arb_onehot : 4'b0000;
    end
  endgenerate

  // Lowest button wins; within it press > long > repeat > release.
  always_comb begin
    arb_any  = 1'b0;
    arb_id   = '0;
    for (int b = N_BTN - 1; b >= 0; b--) begin
      if (|pend_vec[b]) begin
        arb_any = 1'b1;
        arb_id  = ID_W'(b);
      end
    end
    arb_pend = pend_vec[arb_id];
    if (arb_pend[0])      arb_type = 2'd0;
    else if (arb_pend[2]) arb_type = 2'd2;
    else if (arb_pend[3]) arb_type = 2'd3;
    else                  arb_type = 2'd1;
    arb_onehot = 4'b0001 << arb_type;
  end

  assign arb_active = !evt_valid || evt_ready;
  assign arb_load   = arb_active && arb_any;
  assign ovr_hit    = |(set_vec & pend_vec & ~clr_vec);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid   <= 1'b0;
      evt_id      <= '0;
      evt_type    <= 2'd0;
      evt_overrun <= 1'b0;
    end else begin
      if (arb_active) begin
        evt_valid <= arb_any;
        if (arb_any) begin
          evt_id   <= arb_id;
          evt_type <= arb_type;
        end
      end
      if (ovr_hit) evt_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2.
// Expectations follow BTN_AUTO_REPEAT_EN when it is defined for the build.
module tb_button_event_ctrl;
  localparam int N_BTN = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_en;
  logic [3:0] db_level = 4'b0000;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [1:0] evt_type;
  logic       evt_ready = 1'b0;
  logic       evt_overrun;

  button_event_ctrl #(
    .N_BTN(N_BTN), .TICK_DIV(4), .LONG_TICKS(3), .REPEAT_TICKS(2)
  ) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .db_level(db_level),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_type(evt_type),
    .evt_ready(evt_ready), .evt_overrun(evt_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int ev_q[$];
  int ev_cyc[$];
  int passed = 0;
  int total = 0;
  int acyc = 0;

  // Transfer log: entry = id*4 + type, stamped with the cycle it was visible.
  always @(posedge clk) begin
    if (evt_valid && evt_ready) begin
      ev_q.push_back(int'(evt_id) * 4 + int'(evt_type));
      ev_cyc.push_back(cyc);
      $display("evt id=%0d type=%0d cycle=%0d", evt_id, evt_type, cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int qget(input int i);
    return (i < ev_q.size()) ? ev_q[i] : -1;
  endfunction

  function automatic int cget(input int i);
    return (i < ev_cyc.size()) ? ev_cyc[i] : -1;
  endfunction

  // Drive a new level just after a sample strobe; the next eval sees it.
  task automatic apply(input logic [3:0] v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_en && n < 20);
    if (!sample_en) chk("tick_timeout", 0, 1);
    db_level = v;
    acyc = cyc;
  endtask

  task automatic clear_log();
    ev_q.delete();
    ev_cyc.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat;
    int t0;
    int n_exp;
    int exp_e[5];
    int exp_o[5];

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sample_en", int'(sample_en), 0);
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_id_type", int'({evt_id, evt_type}), 0);
    chk("rst_overrun", int'(evt_overrun), 0);

    // Prescaler: high on cycles 3, 7, 11 after release
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 pat[i] = sample_en;
    end
    chk("presc_pattern", int'(pat), 32'h444);

    // Short press of btn2
    evt_ready = 1'b1;
    clear_log();
    apply(4'b0100);
    t0 = acyc;
    apply(4'b0100);
    apply(4'b0000);
    apply(4'b0000);
    repeat (4) @(negedge clk);
    chk("short_count", ev_q.size(), 2);
    chk("short_ev0", qget(0), 8);
    chk("short_ev1", qget(1), 9);
    chk("short_latency", cget(0) - t0, 3);
    chk("short_rel_time", cget(1) - t0, 11);

    // Long press of btn0 for 9 ticks
    clear_log();
`ifdef BTN_AUTO_REPEAT_EN
    n_exp = 5;
    exp_e = '{0, 2, 3, 3, 1};
    exp_o = '{3, 15, 23, 31, 39};
`else
    n_exp = 3;
    exp_e = '{0, 2, 1, 0, 0};
    exp_o = '{3, 15, 39, 0, 0};
`endif
    apply(4'b0001);
    t0 = acyc;
    for (int i = 1; i < 9; i++) apply(4'b0001);
    apply(4'b0000);
    apply(4'b0000);
    repeat (4) @(negedge clk);
    chk("long_count", ev_q.size(), n_exp);
    for (int i = 0; i < n_exp; i++) begin
      chk($sformatf("long_ev%0d", i), qget(i), exp_e[i]);
      chk($sformatf("long_time%0d", i), cget(i) - t0, exp_o[i]);
    end

    // Arbitration under backpressure: btn1 and btn3 on the same eval
    clear_log();
    evt_ready = 1'b0;
    apply(4'b1010);
    t0 = acyc;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_hold%0d", i), int'({evt_valid, evt_id, evt_type}), 5'b1_01_00);
      if (i < 9) @(negedge clk);
    end
    evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("arb_ev0", qget(0), 4);
    chk("arb_ev1", qget(1), 12);
    chk("arb_first_time", cget(0) - t0, 12);
    chk("arb_back_to_back", cget(1) - cget(0), 1);
    apply(4'b0000);
    apply(4'b0000);
    repeat (4) @(negedge clk);

    // Overrun: btn0 press/release/press behind a stalled btn1 press
    clear_log();
    evt_ready = 1'b0;
    apply(4'b0010);
    apply(4'b0001);
    apply(4'b0000);
    apply(4'b0001);
    chk("ovr_before", int'(evt_overrun), 0);
    repeat (2) @(negedge clk);
    chk("ovr_set", int'(evt_overrun), 1);
    chk("ovr_held_out", int'({evt_valid, evt_id, evt_type}), 5'b1_01_00);
    evt_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("ovr_sticky", int'(evt_overrun), 1);
    apply(4'b0000);
    repeat (4) @(negedge clk);
    chk("ovr_count", ev_q.size(), 5);
    chk("ovr_ev0", qget(0), 4);
    chk("ovr_ev1", qget(1), 0);
    chk("ovr_ev2", qget(2), 1);
    chk("ovr_ev3", qget(3), 5);
    chk("ovr_ev4", qget(4), 1);

    // Reset while btn1 is HELD and an event is stalled
    clear_log();
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) apply(4'b0010);
    repeat (2) @(negedge clk);
    chk("mid_pre_valid", int'({evt_valid, evt_id, evt_type}), 5'b1_01_00);
    reset = 1'b1;
    #1;
    chk("mid_rst_sample_en", int'(sample_en), 0);
    chk("mid_rst_valid", int'(evt_valid), 0);
    chk("mid_rst_id_type", int'({evt_id, evt_type}), 0);
    chk("mid_rst_overrun", int'(evt_overrun), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    evt_ready = 1'b1;
    clear_log();
    apply(4'b0010);
    repeat (5) @(negedge clk);
    chk("mid_fresh_count", ev_q.size(), 1);
    chk("mid_fresh_ev", qget(0), 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
